note_sequencer: RTL

- Upstream driver of the signal generator's register-write bus (write_strobe / address[2:0] / data[4:0]).
- Holds a small programmable step table and plays it at a programmable tempo.
- On each tempo tick it emits a 3-write burst: tone-A period nibble, tone-A volume, channel enables.
- Also forwards host register writes through a one-deep buffer with a valid/ready handshake, so host writes never collide with a burst.

---
 rtl/note_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
// Step sequencer that drives the generator's register-write bus and forwards buffered host writes.
// Build option SEQ_REST_SKIP_EN: rest steps (gate=0) emit only the channel-enable write.
module note_sequencer #(
  parameter int STEPS   = 8,
  parameter int TEMPO_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [TEMPO_W-1:0] tempo_div,
  input  logic [2:0]         seq_len,
  input  logic [1:0]         en_bn,
  input  logic               tbl_we,
  input  logic [2:0]         tbl_addr,
  input  logic [9:0]         tbl_data,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [2:0]         host_addr,
  input  logic [4:0]         host_data,
  output logic               write_strobe,
  output logic [2:0]         address,
  output logic [4:0]         data,
  output logic [2:0]         step_idx,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, S_VOL, S_EN} stateT;

  stateT              state, stateNext;
  logic [TEMPO_W-1:0] tempoCnt;
  logic               tick;
  logic               tickPend;
  logic               bufFull;
  logic [2:0]         bufAddr;
  logic [4:0]         bufData;
  logic [9:0]         stepTable [8];
  logic [9:0]         curEntry;
  logic [4:0]         snapGateVol;
  logic               strobeNext;
  logic [2:0]         addrNext;
  logic [4:0]         dataNext;
  logic               bufClear;
  logic               pendClear;
  logic               snapLoad;
  logic               stepAdvance;

  assign tick       = run && (tempoCnt == tempo_div);
  assign curEntry   = stepTable[step_idx];
  assign host_ready = !bufFull;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst || !run) tempoCnt <= '0;
    else if (tick)   tempoCnt <= '0;
    else             tempoCnt <= tempoCnt + TEMPO_W'(1);
  end

  // A tick that finds one already pending is lost, even if the pending one starts playing this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tickPend <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (tick && tickPend) overrun <= 1'b1;
      if (tick && !tickPend) tickPend <= 1'b1;
      else if (pendClear)    tickPend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bufFull <= 1'b0;
      bufAddr <= '0;
      bufData <= '0;
    end else if (host_valid && !bufFull) begin
      bufFull <= 1'b1;
      bufAddr <= host_addr;
      bufData <= host_data;
    end else if (bufClear) begin
      bufFull <= 1'b0;
    end
  end

  // Entries beyond STEPS do not exist and always read as zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst || i >= STEPS)                     stepTable[i] <= '0;
      else if (tbl_we && tbl_addr == 3'(i))      stepTable[i] <= tbl_data;
    end
  end

  always_comb begin
    stateNext   = state;
    strobeNext  = 1'b0;
    addrNext    = address;
    dataNext    = data;
    bufClear    = 1'b0;
    pendClear   = 1'b0;
    snapLoad    = 1'b0;
    stepAdvance = 1'b0;
    case (state)
      IDLE: begin
        if (bufFull) begin
          strobeNext = 1'b1;
          addrNext   = bufAddr;
          dataNext   = bufData;
          bufClear   = 1'b1;
        end else if (tickPend) begin
          pendClear = 1'b1;
          snapLoad  = 1'b1;
`ifdef SEQ_REST_SKIP_EN
          if (!curEntry[9]) begin
            stateNext = S_EN;
          end else begin
            strobeNext = 1'b1;
            addrNext   = 3'd0;
            dataNext   = curEntry[4:0];
            stateNext  = S_VOL;
          end
`else
          strobeNext = 1'b1;
          addrNext   = 3'd0;
          dataNext   = curEntry[4:0];
          stateNext  = S_VOL;
`endif
        end
      end
      S_VOL: begin
        strobeNext = 1'b1;
        addrNext   = 3'd2;
        dataNext   = {1'b0, snapGateVol[3:0]};
        stateNext  = S_EN;
      end
      S_EN: begin
        strobeNext  = 1'b1;
        addrNext    = 3'd5;
        dataNext    = {2'b00, snapGateVol[4], en_bn};
        stepAdvance = 1'b1;
        stateNext   = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // The note goes out straight from the table; gate and volume are frozen for the rest of the burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      write_strobe <= 1'b0;
      address      <= '0;
      data         <= '0;
      step_idx     <= '0;
      snapGateVol  <= '0;
    end else begin
      state        <= stateNext;
      write_strobe <= strobeNext;
      address      <= addrNext;
      data         <= dataNext;
      if (snapLoad)    snapGateVol <= curEntry[9:5];
      if (stepAdvance) step_idx    <= (step_idx == seq_len) ? 3'd0 : step_idx + 3'd1;
    end
  end

endmodule
